// File: rtl/if_id_fetch_unit.sv
// IF/ID fetch unit: issues I-cache reads at the IF PC, owns the IF/ID pipeline register,
// a single-entry skid buffer for stalled responses, and drops responses killed by a redirect.
module if_id_fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          pc_out,
   input  logic [31:0]          pc_plus4_out,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 icache_resp,
   input  logic [31:0]          icache_rdata,
   output logic                 icache_read,
   output logic [31:0]          icache_address,
   output logic                 load_pc,
   output logic [31:0]          ID_pc,
   output logic [31:0]          ID_pc_plus4,
   output logic [31:0]          ID_instr,
   output logic                 ID_valid,
   output logic [CNT_WIDTH-1:0] bubble_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FETCH   = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [31:0]          id_pc_q, id_pc_d;
   logic [31:0]          id_pc4_q, id_pc4_d;
   logic [31:0]          id_instr_q, id_instr_d;
   logic                 id_valid_q, id_valid_d;
   logic [31:0]          buf_pc_q, buf_pc_d;
   logic [31:0]          buf_pc4_q, buf_pc4_d;
   logic [31:0]          buf_instr_q, buf_instr_d;
   logic [31:0]          disc_addr_q, disc_addr_d;
   logic [CNT_WIDTH-1:0] bubble_q;
   logic                 bubble_inc;

   always_comb begin
      state_d        = state_q;
      id_pc_d        = id_pc_q;
      id_pc4_d       = id_pc4_q;
      id_instr_d     = id_instr_q;
      id_valid_d     = id_valid_q;
      buf_pc_d       = buf_pc_q;
      buf_pc4_d      = buf_pc4_q;
      buf_instr_d    = buf_instr_q;
      disc_addr_d    = disc_addr_q;
      load_pc        = 1'b0;
      icache_read    = 1'b0;
      icache_address = pc_out;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            icache_read = 1'b1;
            if (flush) begin
               load_pc    = 1'b1;
               id_valid_d = 1'b0;
               id_instr_d = NOP_INSTR;
               // Without a response the read must still complete; drain it in DISCARD.
               if (!icache_resp) begin
                  disc_addr_d = pc_out;
                  state_d     = DISCARD;
               end
            end else if (icache_resp) begin
               load_pc = 1'b1;
               if (!stall) begin
                  id_pc_d    = pc_out;
                  id_pc4_d   = pc_plus4_out;
                  id_instr_d = icache_rdata;
                  id_valid_d = 1'b1;
               end else begin
                  buf_pc_d    = pc_out;
                  buf_pc4_d   = pc_plus4_out;
                  buf_instr_d = icache_rdata;
                  state_d     = HOLD;
               end
            end else if (!stall) begin
               id_valid_d = 1'b0;
               id_instr_d = NOP_INSTR;
            end
         end
         HOLD: begin
            if (flush) begin
               buf_pc_d    = '0;
               buf_pc4_d   = '0;
               buf_instr_d = '0;
               id_valid_d  = 1'b0;
               id_instr_d  = NOP_INSTR;
               load_pc     = 1'b1;
               state_d     = FETCH;
            end else if (!stall) begin
               id_pc_d    = buf_pc_q;
               id_pc4_d   = buf_pc4_q;
               id_instr_d = buf_instr_q;
               id_valid_d = 1'b1;
               state_d    = FETCH;
            end
         end
         DISCARD: begin
            icache_read    = 1'b1;
            icache_address = disc_addr_q;
            id_valid_d     = 1'b0;
            id_instr_d     = NOP_INSTR;
            if (flush) load_pc = 1'b1;
            if (icache_resp) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bubble_inc = !stall && !id_valid_d && (bubble_q != {CNT_WIDTH{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         id_pc_q     <= '0;
         id_pc4_q    <= '0;
         id_instr_q  <= NOP_INSTR;
         id_valid_q  <= 1'b0;
         buf_pc_q    <= '0;
         buf_pc4_q   <= '0;
         buf_instr_q <= '0;
         disc_addr_q <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         id_pc_q     <= id_pc_d;
         id_pc4_q    <= id_pc4_d;
         id_instr_q  <= id_instr_d;
         id_valid_q  <= id_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_pc4_q   <= buf_pc4_d;
         buf_instr_q <= buf_instr_d;
         disc_addr_q <= disc_addr_d;
         if (bubble_inc) bubble_q <= bubble_q + CNT_WIDTH'(1);
      end
   end

   assign ID_pc        = id_pc_q;
   assign ID_pc_plus4  = id_pc4_q;
   assign ID_instr     = id_instr_q;
   assign ID_valid     = id_valid_q;
   assign bubble_count = bubble_q;

endmodule

// File: tb/tb_if_id_fetch_unit.sv
// Directed bench for if_id_fetch_unit: models the IF PC register, drives I-cache responses
// by hand and compares against hand-computed values.
module tb_if_id_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_reg;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        flush;
   logic        icache_resp;
   logic [31:0] icache_rdata;
   logic        icache_read;
   logic [31:0] icache_address;
   logic        load_pc;
   logic [31:0] ID_pc;
   logic [31:0] ID_pc_plus4;
   logic [31:0] ID_instr;
   logic        ID_valid;
   logic [3:0]  bubble_count;

   int n_checks = 0;
   int n_errors = 0;

   if_id_fetch_unit #(
      .NOP_INSTR(NOP),
      .CNT_WIDTH(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_out        (pc_reg),
      .pc_plus4_out  (pc_plus4),
      .stall         (stall),
      .flush         (flush),
      .icache_resp   (icache_resp),
      .icache_rdata  (icache_rdata),
      .icache_read   (icache_read),
      .icache_address(icache_address),
      .load_pc       (load_pc),
      .ID_pc         (ID_pc),
      .ID_pc_plus4   (ID_pc_plus4),
      .ID_instr      (ID_instr),
      .ID_valid      (ID_valid),
      .bubble_count  (bubble_count)
   );

   always #5 clk = ~clk;

   // IF PC register: sequential +4, or the redirect target when the load comes with a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_reg <= 32'h60;
      else if (load_pc) pc_reg <= flush ? redirect_pc : pc_reg + 32'd4;
   end
   assign pc_plus4 = pc_reg + 32'd4;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply this cycle's inputs just after the falling edge, then let combinational outputs settle.
   task automatic drive(input logic r, input logic [31:0] d, input logic s, input logic f);
      icache_resp  = r;
      icache_rdata = d;
      stall        = s;
      flush        = f;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      redirect_pc = 32'h0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_eq("rst_valid", 32'(ID_valid), 32'd0);
      check_eq("rst_pc", ID_pc, 32'h0);
      check_eq("rst_pc4", ID_pc_plus4, 32'h0);
      check_eq("rst_instr", ID_instr, NOP);
      check_eq("rst_read", 32'(icache_read), 32'd0);
      check_eq("rst_load_pc", 32'(load_pc), 32'd0);
      check_eq("rst_bubble", 32'(bubble_count), 32'd0);
      rst = 1'b0;
      tick();  // IDLE cycle
      check_eq("idle_bubble", 32'(bubble_count), 32'd1);

      // 1: back-to-back fetches, response one cycle after each read
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         check_eq("t1_read", 32'(icache_read), 32'd1);
         check_eq("t1_addr", icache_address, 32'h60 + 32'(4 * k));
         check_eq("t1_no_load", 32'(load_pc), 32'd0);
         tick();
         check_eq("t1_bubble_valid", 32'(ID_valid), 32'd0);
         check_eq("t1_bubble_instr", ID_instr, NOP);
         drive(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
         check_eq("t1_load", 32'(load_pc), 32'd1);
         tick();
         check_eq("t1_id_pc", ID_pc, 32'h60 + 32'(4 * k));
         check_eq("t1_id_pc4", ID_pc_plus4, 32'h64 + 32'(4 * k));
         check_eq("t1_id_instr", ID_instr, 32'hA000_0000 + 32'(k));
         check_eq("t1_id_valid", 32'(ID_valid), 32'd1);
      end

      // Redirect to 0x100 with flush & resp: word dropped, stay in FETCH
      redirect_pc = 32'h100;
      drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b1);
      check_eq("fr_load", 32'(load_pc), 32'd1);
      tick();
      check_eq("fr_valid", 32'(ID_valid), 32'd0);
      check_eq("fr_instr", ID_instr, NOP);

      // 2: response for 0x100 under a 3-cycle stall goes through HOLD
      drive(1'b1, 32'h0000_A100, 1'b1, 1'b0);
      check_eq("t2_addr", icache_address, 32'h100);
      check_eq("t2_load", 32'(load_pc), 32'd1);
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         check_eq("t2_hold_read", 32'(icache_read), 32'd0);
         check_eq("t2_hold_load", 32'(load_pc), 32'd0);
         tick();
         check_eq("t2_hold_valid", 32'(ID_valid), 32'd0);
         check_eq("t2_hold_pc", ID_pc, 32'h68);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("t2_release_load", 32'(load_pc), 32'd0);
      tick();
      check_eq("t2_id_pc", ID_pc, 32'h100);
      check_eq("t2_id_pc4", ID_pc_plus4, 32'h104);
      check_eq("t2_id_instr", ID_instr, 32'h0000_A100);
      check_eq("t2_id_valid", 32'(ID_valid), 32'd1);

      // 3: flush without response -> DISCARD, late 0xDEADBEEF is dropped
      redirect_pc = 32'h200;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("t3_addr_flush", icache_address, 32'h104);
      check_eq("t3_load_flush", 32'(load_pc), 32'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         check_eq("t3_disc_read", 32'(icache_read), 32'd1);
         check_eq("t3_disc_addr", icache_address, 32'h104);
         check_eq("t3_disc_load", 32'(load_pc), 32'd0);
         tick();
         check_eq("t3_disc_valid", 32'(ID_valid), 32'd0);
      end
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check_eq("t3_resp_load", 32'(load_pc), 32'd0);
      tick();
      check_eq("t3_drop_instr", ID_instr, NOP);
      check_eq("t3_drop_valid", 32'(ID_valid), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("t3_new_addr", icache_address, 32'h200);

      // 4: flush + stall in HOLD drops the buffer
      drive(1'b1, 32'h0000_B200, 1'b1, 1'b0);
      tick();
      redirect_pc = 32'h300;
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      check_eq("t4_load", 32'(load_pc), 32'd1);
      tick();
      check_eq("t4_valid", 32'(ID_valid), 32'd0);
      check_eq("t4_instr", ID_instr, NOP);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("t4_fetch_read", 32'(icache_read), 32'd1);
      check_eq("t4_fetch_addr", icache_address, 32'h300);
      tick();
      check_eq("t4_no_buffer", 32'(ID_valid), 32'd0);

      // 5: asynchronous reset mid-request
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("t5_pre_read", 32'(icache_read), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t5_read", 32'(icache_read), 32'd0);
      check_eq("t5_valid", 32'(ID_valid), 32'd0);
      check_eq("t5_instr", ID_instr, 32'h0000_0013);
      check_eq("t5_bubble", 32'(bubble_count), 32'd0);
      tick();
      rst = 1'b0;
      tick();  // IDLE cycle

      // 6: bubble counter saturation, then PC wrap of ID_pc_plus4
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         tick();
      end
      check_eq("t6_bubble_sat", 32'(bubble_count), 32'd15);
      redirect_pc = 32'hFFFF_FFFC;
      drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'h0000_C0DE, 1'b0, 1'b0);
      check_eq("t6_addr", icache_address, 32'hFFFF_FFFC);
      tick();
      check_eq("t6_id_pc", ID_pc, 32'hFFFF_FFFC);
      check_eq("t6_id_pc4", ID_pc_plus4, 32'h0);
      check_eq("t6_id_instr", ID_instr, 32'h0000_C0DE);
      check_eq("t6_bubble_hold", 32'(bubble_count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
